// File: rtl/saber_pkt_axil_reader.sv
// AXI4-Lite master that drains one packet from the packet register slave.
// Sequence: poll the status register until packet-ready (or poll limit),
// read every data word in order, hand each word to a valid/ready stream,
// then write the clear register and report done / error.
// Only one AXI transaction is ever outstanding. The data width must be 32.
module saber_pkt_axil_reader #(
  parameter int C_M00_AXI_DATA_WIDTH = 32,
  parameter int C_M00_AXI_ADDR_WIDTH = 8,
  parameter logic [C_M00_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR   = 8'h00,
  parameter int N_WORDS = 56,
  parameter logic [C_M00_AXI_ADDR_WIDTH-1:0] STATUS_OFFSET = 8'hE4,
  parameter logic [C_M00_AXI_ADDR_WIDTH-1:0] CLR_OFFSET    = 8'hE0,
  parameter int POLL_GAP  = 16,
  parameter int MAX_POLLS = 1024
) (
  input  logic                              m00_axi_aclk,
  input  logic                              m00_axi_aresetn,
  input  logic                              start_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              err_o,
  output logic [C_M00_AXI_DATA_WIDTH-1:0]   word_o,
  output logic [5:0]                        word_idx_o,
  output logic                              word_valid_o,
  input  logic                              word_ready_i,
  output logic [C_M00_AXI_ADDR_WIDTH-1:0]   m00_axi_awaddr,
  output logic [2:0]                        m00_axi_awprot,
  output logic                              m00_axi_awvalid,
  input  logic                              m00_axi_awready,
  output logic [C_M00_AXI_DATA_WIDTH-1:0]   m00_axi_wdata,
  output logic [C_M00_AXI_DATA_WIDTH/8-1:0] m00_axi_wstrb,
  output logic                              m00_axi_wvalid,
  input  logic                              m00_axi_wready,
  input  logic [1:0]                        m00_axi_bresp,
  input  logic                              m00_axi_bvalid,
  output logic                              m00_axi_bready,
  output logic [C_M00_AXI_ADDR_WIDTH-1:0]   m00_axi_araddr,
  output logic [2:0]                        m00_axi_arprot,
  output logic                              m00_axi_arvalid,
  input  logic                              m00_axi_arready,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0]   m00_axi_rdata,
  input  logic [1:0]                        m00_axi_rresp,
  input  logic                              m00_axi_rvalid,
  output logic                              m00_axi_rready
);

  localparam int AW = C_M00_AXI_ADDR_WIDTH;
  localparam int DW = C_M00_AXI_DATA_WIDTH;
  localparam int GW = (POLL_GAP  > 1) ? $clog2(POLL_GAP)  : 1;
  localparam int PW = (MAX_POLLS > 1) ? $clog2(MAX_POLLS) : 1;

  localparam logic [AW-1:0] STATUS_ADDR = C_BASE_ADDR + STATUS_OFFSET;
  localparam logic [AW-1:0] CLR_ADDR    = C_BASE_ADDR + CLR_OFFSET;
  localparam logic [5:0]    LAST_IDX    = 6'(N_WORDS - 1);

  typedef enum logic [3:0] {
    IDLE, POLL_AR, POLL_R, GAP, RD_AR, RD_R, PUSH, CLR_W, CLR_B, FIN
  } state_t;

  state_t          state;
  logic [PW-1:0]   poll_cnt;
  logic [GW-1:0]   gap_cnt;
  logic            aw_done;
  logic            w_done;

  // Byte address of data word idx, wrapping inside the slave address space.
  function automatic logic [AW-1:0] word_addr(input logic [5:0] idx);
    return C_BASE_ADDR + AW'({idx, 2'b00});
  endfunction

  assign m00_axi_awprot = 3'b000;
  assign m00_axi_arprot = 3'b000;
  assign m00_axi_wstrb  = '1;

  // Transfer sequencer; every output it drives is a register.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // branch below sees the pre-edge values of the registers it reads.
  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      state           <= IDLE;
      poll_cnt        <= '0;
      gap_cnt         <= '0;
      aw_done         <= 1'b0;
      w_done          <= 1'b0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      err_o           <= 1'b0;
      word_o          <= '0;
      word_idx_o      <= '0;
      word_valid_o    <= 1'b0;
      m00_axi_awaddr  <= '0;
      m00_axi_awvalid <= 1'b0;
      m00_axi_wdata   <= '0;
      m00_axi_wvalid  <= 1'b0;
      m00_axi_bready  <= 1'b0;
      m00_axi_araddr  <= '0;
      m00_axi_arvalid <= 1'b0;
      m00_axi_rready  <= 1'b0;
    end else begin
      // done_o is a single-cycle pulse; only the transition into FIN raises it.
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            busy_o          <= 1'b1;
            err_o           <= 1'b0;
            poll_cnt        <= '0;
            m00_axi_araddr  <= STATUS_ADDR;
            m00_axi_arvalid <= 1'b1;
            state           <= POLL_AR;
          end
        end
        POLL_AR: begin
          if (m00_axi_arready) begin
            m00_axi_arvalid <= 1'b0;
            m00_axi_rready  <= 1'b1;
            state           <= POLL_R;
          end
        end
        POLL_R: begin
          if (m00_axi_rvalid) begin
            m00_axi_rready <= 1'b0;
            if (m00_axi_rresp != 2'b00) begin
              err_o  <= 1'b1;
              busy_o <= 1'b0;
              done_o <= 1'b1;
              state  <= FIN;
            end else if (m00_axi_rdata[0]) begin
              word_idx_o      <= '0;
              m00_axi_araddr  <= word_addr(6'd0);
              m00_axi_arvalid <= 1'b1;
              state           <= RD_AR;
            end else if (MAX_POLLS != 0 && poll_cnt == PW'(MAX_POLLS - 1)) begin
              // poll_cnt counts failed polls before this one, so this read
              // was the MAX_POLLS-th.
              err_o  <= 1'b1;
              busy_o <= 1'b0;
              done_o <= 1'b1;
              state  <= FIN;
            end else begin
              poll_cnt <= poll_cnt + PW'(1);
              gap_cnt  <= GW'(POLL_GAP - 1);
              state    <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            m00_axi_araddr  <= STATUS_ADDR;
            m00_axi_arvalid <= 1'b1;
            state           <= POLL_AR;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        RD_AR: begin
          if (m00_axi_arready) begin
            m00_axi_arvalid <= 1'b0;
            m00_axi_rready  <= 1'b1;
            state           <= RD_R;
          end
        end
        RD_R: begin
          if (m00_axi_rvalid) begin
            m00_axi_rready <= 1'b0;
            word_o         <= m00_axi_rdata;
            if (m00_axi_rresp != 2'b00) begin
              err_o  <= 1'b1;
              busy_o <= 1'b0;
              done_o <= 1'b1;
              state  <= FIN;
            end else begin
              word_valid_o <= 1'b1;
              state        <= PUSH;
            end
          end
        end
        PUSH: begin
          if (word_ready_i) begin
            word_valid_o <= 1'b0;
            if (word_idx_o == LAST_IDX) begin
              m00_axi_awaddr  <= CLR_ADDR;
              m00_axi_wdata   <= DW'(1);
              m00_axi_awvalid <= 1'b1;
              m00_axi_wvalid  <= 1'b1;
              aw_done         <= 1'b0;
              w_done          <= 1'b0;
              state           <= CLR_W;
            end else begin
              word_idx_o      <= word_idx_o + 6'd1;
              m00_axi_araddr  <= word_addr(word_idx_o + 6'd1);
              m00_axi_arvalid <= 1'b1;
              state           <= RD_AR;
            end
          end
        end
        CLR_W: begin
          // Address and data channels complete independently, in any order.
          if (m00_axi_awvalid && m00_axi_awready) begin
            m00_axi_awvalid <= 1'b0;
            aw_done         <= 1'b1;
          end
          if (m00_axi_wvalid && m00_axi_wready) begin
            m00_axi_wvalid <= 1'b0;
            w_done         <= 1'b1;
          end
          if (aw_done && w_done) begin
            m00_axi_bready <= 1'b1;
            state          <= CLR_B;
          end
        end
        CLR_B: begin
          if (m00_axi_bvalid) begin
            m00_axi_bready <= 1'b0;
            err_o          <= (m00_axi_bresp != 2'b00);
            busy_o         <= 1'b0;
            done_o         <= 1'b1;
            state          <= FIN;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_saber_pkt_axil_reader.sv
// Bench for saber_pkt_axil_reader: a small AXI4-Lite packet slave and a word
// sink run on the falling edge; expected AR addresses, clear writes, words
// and done/err results are queued by the stimulus and popped by the monitor.
module tb_saber_pkt_axil_reader;

  localparam int NW = 56;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        busy_o, done_o, err_o;
  logic [31:0] word_o;
  logic [5:0]  word_idx_o;
  logic        word_valid_o;
  logic        word_ready_i = 1'b0;
  logic [7:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready = 1'b0, wready = 1'b0, arready = 1'b0;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp = 2'b00, rresp = 2'b00;
  logic        bvalid = 1'b0, rvalid = 1'b0;
  logic [31:0] rdata = '0;

  always #5 clk = ~clk;

  saber_pkt_axil_reader #(.POLL_GAP(16), .MAX_POLLS(4)) dut (
    .m00_axi_aclk(clk), .m00_axi_aresetn(rst_n),
    .start_i(start_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .word_o(word_o), .word_idx_o(word_idx_o),
    .word_valid_o(word_valid_o), .word_ready_i(word_ready_i),
    .m00_axi_awaddr(awaddr), .m00_axi_awprot(awprot),
    .m00_axi_awvalid(awvalid), .m00_axi_awready(awready),
    .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb),
    .m00_axi_wvalid(wvalid), .m00_axi_wready(wready),
    .m00_axi_bresp(bresp), .m00_axi_bvalid(bvalid), .m00_axi_bready(bready),
    .m00_axi_araddr(araddr), .m00_axi_arprot(arprot),
    .m00_axi_arvalid(arvalid), .m00_axi_arready(arready),
    .m00_axi_rdata(rdata), .m00_axi_rresp(rresp),
    .m00_axi_rvalid(rvalid), .m00_axi_rready(rready)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Slave register contents for data word k.
  function automatic logic [31:0] word_pat(input int k);
    return {8'h5A, 8'(k), 16'hFFFF - 16'(k)};
  endfunction

  // Slave / sink configuration.
  int         ready_on_poll = 1;   // status read number that first reports ready, 0 = never
  int         err_word = -1;       // data word answered with SLVERR
  logic [1:0] bresp_cfg = 2'b00;
  int         aw_wait = 0, w_wait = 0;
  bit         rnd = 1'b0;
  int         stall_idx = -1;      // word index the sink refuses
  int         status_reads = 0;

  // Scoreboard.
  logic [7:0]  exp_ar[$];
  logic [7:0]  exp_wr[$];
  logic [37:0] exp_wd[$];
  logic        exp_err[$];
  int          poll_cyc[$];
  int          done_cnt = 0;
  int          lat_expect = -1;
  int          start_cyc = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave, sink and monitor state.
  bit          hs_ar, hs_r, hs_aw, hs_w, hs_b, hs_wd;
  bit          rd_pend, aw_got, w_got;
  logic [7:0]  rd_addr;
  int          r_cnt, aw_cnt, w_cnt;
  bit          p_arv, p_wv;
  logic [7:0]  p_ara;
  logic [31:0] p_wo;
  logic [5:0]  p_wi;

  // Falling-edge slave + sink + monitor: retire the handshakes of the last
  // rising edge, drive new responses/readies, then check what the coming
  // rising edge will transfer.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        arready = 1'b0; awready = 1'b0; wready = 1'b0;
        rvalid = 1'b0; bvalid = 1'b0; word_ready_i = 1'b0;
        hs_ar = 0; hs_r = 0; hs_aw = 0; hs_w = 0; hs_b = 0; hs_wd = 0;
        rd_pend = 0; aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0;
        p_arv = 0; p_wv = 0;
      end else begin
        if (hs_r) rvalid = 1'b0;
        if (hs_b) begin bvalid = 1'b0; aw_got = 0; w_got = 0; end
        if (hs_ar) begin
          rd_pend = 1; rd_addr = p_ara; r_cnt = rnd ? int'($urandom_range(0, 2)) : 0;
        end
        if (hs_aw) aw_got = 1;
        if (hs_w)  w_got  = 1;

        if (rd_pend && !rvalid) begin
          if (r_cnt == 0) begin
            rd_pend = 0;
            rvalid  = 1'b1;
            if (rd_addr == 8'hE4) begin
              status_reads++;
              rdata = (ready_on_poll != 0 && status_reads >= ready_on_poll) ? 32'h0000_0001 : 32'h8000_0000;
              rresp = 2'b00;
            end else begin
              rdata = word_pat(int'(rd_addr) / 4);
              rresp = (int'(rd_addr) / 4 == err_word) ? 2'b10 : 2'b00;
            end
          end else begin
            r_cnt--;
          end
        end
        if (aw_got && w_got && !bvalid) begin bvalid = 1'b1; bresp = bresp_cfg; end

        arready = arvalid && (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
        if (awvalid && !aw_got) begin
          awready = rnd ? 1'($urandom_range(0, 1)) : (aw_cnt >= aw_wait); aw_cnt++;
        end else begin awready = 1'b0; aw_cnt = 0; end
        if (wvalid && !w_got) begin
          wready = rnd ? 1'($urandom_range(0, 1)) : (w_cnt >= w_wait); w_cnt++;
        end else begin wready = 1'b0; w_cnt = 0; end
        word_ready_i = rnd ? 1'($urandom_range(0, 1)) : (int'(word_idx_o) != stall_idx);

        // Outputs must hold while valid waits for ready.
        if (p_arv) begin
          check("arvalid held", arvalid, 1);
          check("araddr stable", araddr, p_ara);
        end
        if (p_wv) begin
          check("word_valid held", word_valid_o, 1);
          check("word_o stable", word_o, p_wo);
          check("word_idx stable", word_idx_o, p_wi);
        end

        hs_ar = arvalid && arready;
        hs_r  = rvalid && rready;
        hs_aw = awvalid && awready;
        hs_w  = wvalid && wready;
        hs_b  = bvalid && bready;
        hs_wd = word_valid_o && word_ready_i;

        if (hs_ar) begin
          check("ar expected", exp_ar.size() != 0, 1);
          if (exp_ar.size() != 0) check("araddr", araddr, exp_ar.pop_front());
          if (araddr == 8'hE4) poll_cyc.push_back(cyc);
        end
        if (hs_aw) begin
          check("aw expected", exp_wr.size() != 0, 1);
          if (exp_wr.size() != 0) check("awaddr", awaddr, exp_wr.pop_front());
        end
        if (hs_w) begin
          check("wdata", wdata, 32'h1);
          check("wstrb", wstrb, 4'hF);
        end
        if (hs_wd) begin
          check("word expected", exp_wd.size() != 0, 1);
          if (exp_wd.size() != 0) begin
            logic [37:0] e;
            e = exp_wd.pop_front();
            check("word_idx", word_idx_o, e[37:32]);
            check("word_o", word_o, e[31:0]);
          end
        end
        if (done_o) begin
          done_cnt++;
          check("done expected", exp_err.size() != 0, 1);
          if (exp_err.size() != 0) check("err_o at done", err_o, exp_err.pop_front());
          check("busy low at done", busy_o, 0);
          if (lat_expect >= 0) begin
            check("done latency", cyc - start_cyc, lat_expect);
            lat_expect = -1;
          end
        end

        p_arv = arvalid && !hs_ar;  p_ara = araddr;
        p_wv  = word_valid_o && !hs_wd;
        p_wo  = word_o;  p_wi = word_idx_o;
      end
    end
  end

  // Queue everything one transfer should produce.
  task automatic expect_xfer(input int polls, input int n_rd, input int n_push,
                             input bit wr, input bit err, input bit dn);
    for (int i = 0; i < polls; i++) exp_ar.push_back(8'hE4);
    for (int k = 0; k < n_rd; k++) exp_ar.push_back(8'(4 * k));
    for (int k = 0; k < n_push; k++) exp_wd.push_back({6'(k), word_pat(k)});
    if (wr) exp_wr.push_back(8'hE0);
    if (dn) exp_err.push_back(err);
    poll_cyc.delete();
    status_reads = 0;
  endtask

  task automatic start_pulse();
    @(negedge clk);
    start_cyc = cyc;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("busy after start", busy_o, 1);
    check("arvalid after start", arvalid, 1);
    check("err cleared by start", err_o, 0);
  endtask

  task automatic wait_done(input int budget);
    int base = done_cnt;
    int n = 0;
    while (done_cnt == base && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done within budget", done_cnt != base, 1);
  endtask

  task automatic check_drained();
    check("ar reads left", exp_ar.size(), 0);
    check("writes left", exp_wr.size(), 0);
    check("words left", exp_wd.size(), 0);
    check("done results left", exp_err.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy_o"}, busy_o, 0);
    check({tag, " done_o"}, done_o, 0);
    check({tag, " err_o"}, err_o, 0);
    check({tag, " word_valid_o"}, word_valid_o, 0);
    check({tag, " word_o"}, word_o, 0);
    check({tag, " word_idx_o"}, word_idx_o, 0);
    check({tag, " arvalid"}, arvalid, 0);
    check({tag, " araddr"}, araddr, 0);
    check({tag, " rready"}, rready, 0);
    check({tag, " awvalid"}, awvalid, 0);
    check({tag, " wvalid"}, wvalid, 0);
    check({tag, " bready"}, bready, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #12;
    check_all_zero("reset");
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1: ready on first poll, zero-wait slave and sink.
    expect_xfer(1, NW, NW, 1, 0, 1);
    lat_expect = 174;
    start_pulse();
    wait_done(1000);
    check_drained();

    // 2: ready on the third poll; polls are 2 + POLL_GAP cycles apart.
    ready_on_poll = 3;
    expect_xfer(3, NW, NW, 1, 0, 1);
    start_pulse();
    wait_done(1000);
    check_drained();
    check("status reads", poll_cyc.size(), 3);
    for (int i = 1; i < poll_cyc.size(); i++)
      check("poll spacing", poll_cyc[i] - poll_cyc[i-1], 18);

    // 3: never ready; times out after MAX_POLLS=4 reads.
    ready_on_poll = 0;
    expect_xfer(4, 0, 0, 0, 1, 1);
    start_pulse();
    wait_done(500);
    check_drained();
    check("timeout status reads", poll_cyc.size(), 4);

    // 4: SLVERR on word 10; words 0..9 pushed, no clear write.
    ready_on_poll = 1;
    err_word = 10;
    expect_xfer(1, 11, 10, 0, 1, 1);
    start_pulse();
    wait_done(500);
    check_drained();
    err_word = -1;

    // 5: random ready delays and sink backpressure.
    rnd = 1'b1;
    expect_xfer(1, NW, NW, 1, 0, 1);
    start_pulse();
    wait_done(3000);
    check_drained();
    rnd = 1'b0;

    // 6: awready 3 cycles before wready, SLVERR on B; start mid-transfer ignored.
    aw_wait = 1; w_wait = 4; bresp_cfg = 2'b10;
    expect_xfer(1, NW, NW, 1, 1, 1);
    start_pulse();
    repeat (30) @(negedge clk);
    check("busy mid-transfer", busy_o, 1);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_done(1000);
    check_drained();
    repeat (3) @(negedge clk);
    check("err_o held", err_o, 1);
    check("busy idle", busy_o, 0);
    aw_wait = 0; w_wait = 0; bresp_cfg = 2'b00;

    // 7: reset while word 20 waits in PUSH; no write, no done.
    stall_idx = 20;
    expect_xfer(1, 21, 20, 0, 0, 0);
    start_pulse();
    n = 0;
    while (!(word_valid_o && word_idx_o == 6'd20) && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("reached word 20", word_valid_o && word_idx_o == 6'd20, 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("mid reset");
    n = done_cnt;
    stall_idx = -1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("no done after reset", done_cnt, n);
    check_drained();

    // 8: normal transfer after the abort.
    expect_xfer(1, NW, NW, 1, 0, 1);
    lat_expect = 174;
    start_pulse();
    wait_done(1000);
    check_drained();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/saber_pkt_axil_reader.md
# saber_pkt_axil_reader

PL-side AXI4-Lite master that drains one 56-word packet from the AXI4-Lite packet register slave and acknowledges it. On a start pulse it polls the slave status register until the packet-ready bit is set or a poll limit expires. It then reads the 56 data words in order and hands each one to a downstream valid/ready word stream. Finally it writes the clear register and reports done or error.

## Interface
Parameters:
- C_M00_AXI_DATA_WIDTH, 32: AXI data width; only 32 is supported.
- C_M00_AXI_ADDR_WIDTH, 8: AXI address width.
- C_BASE_ADDR, 8'h00: slave base address; all offsets are added to it modulo 2^ADDR_WIDTH.
- N_WORDS, 56: data words per packet, at offsets 0x00..4*(N_WORDS-1).
- STATUS_OFFSET, 8'hE4: status register; bit0 = packet ready.
- CLR_OFFSET, 8'hE0: clear register; writing 1 to bit0 pulses the slave clear.
- POLL_GAP, 16: idle cycles between status polls, minimum 1.
- MAX_POLLS, 1024: status reads before timeout; 0 means never time out.

Ports:
- m00_axi_aclk  in  1  sole clock.
- m00_axi_aresetn  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle pulse that begins a transfer; ignored while busy_o=1.
- busy_o  out  1  high from the cycle after an accepted start until done_o.
- done_o  out  1  one-cycle pulse at the end of every transfer, successful or not.
- err_o  out  1  high when the last transfer failed; held until the next accepted start.
- word_o  out  32  packet word.
- word_idx_o  out  6  index of word_o, 0..N_WORDS-1.
- word_valid_o / word_ready_i  out/in  1/1  stream handshake; a word transfers when both are high.
- AXI4-Lite master channels m00_axi_{awaddr, awprot, awvalid, awready, wdata, wstrb, wvalid, wready, bresp, bvalid, bready, araddr, arprot, arvalid, arready, rdata, rresp, rvalid, rready} use standard widths.
- awprot and arprot are fixed at 3'b000.
- wstrb is fixed at 4'hF.

## Operation
State machine states: IDLE, POLL_AR, POLL_R, GAP, RD_AR, RD_R, PUSH, CLR_W, CLR_B, FIN.
- IDLE: start_i=1 moves to POLL_AR. It also clears err_o and the poll counter, and sets busy_o.
- POLL_AR: araddr=BASE+STATUS_OFFSET and arvalid=1, held until arready=1, then go to POLL_R.
- POLL_R: rready=1. Outcomes on rvalid=1:
  - rresp≠0: go to FIN with err_o=1.
  - rdata[0]=1: reset the word index to 0 and go to RD_AR.
  - otherwise, if the poll count has reached MAX_POLLS (MAX_POLLS≠0): go to FIN with err_o=1.
  - otherwise: increment the poll count and go to GAP.
- GAP: wait POLL_GAP cycles, then go to POLL_AR.
- RD_AR: araddr=BASE+4*idx and arvalid=1, held until arready=1, then go to RD_R.
- RD_R: rready=1. On rvalid=1, latch rdata into word_o.
  - rresp≠0: go to FIN with err_o=1; no word is pushed.
  - otherwise: go to PUSH.
- PUSH: word_valid_o=1, with word_o and word_idx_o stable, until word_ready_i=1.
  - If idx=N_WORDS-1, go to CLR_W.
  - Otherwise increment idx and go to RD_AR.
- CLR_W: awaddr=BASE+CLR_OFFSET, wdata=32'h1, awvalid=1, wvalid=1. Each valid drops independently after its own ready. When both handshakes are complete, go to CLR_B.
- CLR_B: bready=1. On bvalid=1, set err_o=(bresp≠0), then go to FIN.
- FIN: done_o=1 and busy_o=0, then go to IDLE.
- Only one AXI transaction is outstanding at a time, and there is no read pipelining. The clear write is skipped whenever the transfer errors.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE and every output is 0, including all AXI valid/ready outputs, word_o, word_idx_o, done_o, err_o and busy_o.
- Reset mid-transfer aborts immediately. No clear write is issued and no done pulse is produced.
- start_i accepted at cycle t: busy_o=1 and arvalid=1 at t+1.
- The master never drops any valid before its handshake, and never changes address or data while a valid is high.
- Per-word cost with zero-wait slave and sink: AR (1) + R (1) + PUSH (1) = 3 cycles. Ideal packet time = status read 2 + 56×3 + clear 2 (W) + 1 (B) + FIN 1.
- done_o lasts exactly 1 cycle. Under the ideal timing above, the next start is accepted in the cycle after FIN.
- start_i while busy is dropped, with no queuing.
- word_ready_i held low stalls in PUSH indefinitely. There is no timeout on the stream or on AXI handshakes.
- awready and wready may arrive in either order or in the same cycle. Both must be seen before entering CLR_B.

## Test plan
- Ready already set, zero-wait slave and sink:
  - start → 56 words with idx 0..55 and word_o equal to the slave registers.
  - ARADDR sequence: 0xE4, 0x00, 0x04 … 0xDC.
  - One write: 0xE0 ← 0x1, bresp=0.
  - done_o=1 and err_o=0 at cycle 174 after start.
- Ready set on the 3rd poll, POLL_GAP=16: exactly 3 reads of 0xE4, separated by 16 idle cycles, then a normal drain.
- MAX_POLLS=4, ready never set: 4 status reads, then done_o=1 and err_o=1, with no data reads and no 0xE0 write.
- rresp=2'b10 on the word-10 read: words 0..9 pushed, done_o=1 and err_o=1, and no 0xE0 write.
- Random backpressure on word_ready_i and random AXI ready delays: words are delivered in order, no word is lost or duplicated, and outputs stay stable while valid is high.
- Other cases in one sequence:
  - awready 3 cycles before wready, then bresp=2'b10 → err_o=1.
  - start_i pulsed mid-transfer → ignored.
  - aresetn=0 during word 20 → all outputs 0 and no write.
